// File: rtl/prefetch_controller.sv
// Sequencer for the 4-stage instruction prefetch register: fetch addressing, memory handshake, shift/flush strobes.
// Build with PREFETCH_STATS_EN defined to add saturating flush/stall counters; otherwise both counters read 0.
module prefetch_controller #(
    parameter int                    word_size    = 16,
    parameter int                    addr_width   = 16,
    parameter int                    depth        = 4,
    parameter logic [addr_width-1:0] reset_vector = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  mem_req,
    output logic [addr_width-1:0] mem_addr,
    input  logic                  mem_ack,
    output logic                  ir_write_enable,
    output logic                  ir_reset,
    input  logic                  stall,
    input  logic                  branch_taken,
    input  logic [addr_width-1:0] branch_target,
    input  logic                  halt,
    output logic                  instr_valid,
    output logic [addr_width-1:0] pc_out,
    output logic [15:0]           flush_count,
    output logic [15:0]           stall_count
);

    if (depth != 4 || word_size < 1) begin : g_param_check
        $error("prefetch_controller: depth must be 4 to match the prefetch register");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [addr_width-1:0] fetch_pc;
    logic [depth-1:0]      valid;
    logic [addr_width-1:0] stage_addr [depth];

    logic consume;
    logic blocked;
    logic acc;
    logic shift_en;

    assign consume  = valid[depth-1] & ~stall;
    assign blocked  = valid[depth-1] & stall;

    // Request, accept and shift are kept as separate continuous assigns so the
    // combinational chain mem_req -> acc -> shift_en stays acyclic at block level.
    assign mem_req  = ~reset & (state == S_RUN) & ~halt & ~blocked & ~branch_taken;
    assign acc      = mem_req & mem_ack;
    assign shift_en = ~reset & ~branch_taken & (state != S_FLUSH)
                    & (acc | consume | (~valid[depth-1] & |valid[depth-2:0]));

    assign mem_addr        = fetch_pc;
    assign ir_write_enable = shift_en;
    assign instr_valid     = valid[depth-1];
    assign pc_out          = stage_addr[depth-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_next = state;
        ir_reset   = reset;
        case (state)
            S_IDLE:  state_next = S_RUN;
            S_RUN:   if (halt) state_next = S_HALT;
            S_FLUSH: begin
                ir_reset   = 1'b1;
                state_next = halt ? S_HALT : S_RUN;
            end
            S_HALT:  if (!halt) state_next = S_RUN;
            default: state_next = S_IDLE;
        endcase
        if (branch_taken) state_next = S_FLUSH;
    end

    // A branch discards any same-cycle accept and leaves the stage addresses
    // alone; only the valid bits matter for what the decoder sees.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= reset_vector;
            valid    <= '0;
            // NOTE: the stage address array is reset explicitly so pc_out reads 0 after reset.
            for (int i = 0; i < depth; i++) stage_addr[i] <= '0;
        end else if (branch_taken) begin
            fetch_pc <= branch_target;
            valid    <= '0;
        end else begin
            if (acc) fetch_pc <= fetch_pc + addr_width'(1);
            if (shift_en) begin
                valid         <= {valid[depth-2:0], acc};
                stage_addr[0] <= fetch_pc;
                for (int i = depth - 1; i > 0; i--) stage_addr[i] <= stage_addr[i-1];
            end
        end
    end

`ifdef PREFETCH_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            flush_count <= '0;
            stall_count <= '0;
        end else begin
            if (branch_taken && flush_count != 16'hFFFF) flush_count <= flush_count + 16'd1;
            if (blocked && stall_count != 16'hFFFF)      stall_count <= stall_count + 16'd1;
        end
    end
`else
    assign flush_count = '0;
    assign stall_count = '0;
`endif

endmodule
